// File: rtl/bin_dot_pkg.sv
// Shared definitions for the binarized dot-product read sequencer and any
// other reader sitting on mem_sys: default widths, FSM states, bank codes.
package bin_dot_pkg;

    localparam int AW_X_DEF  = 10;
    localparam int AW_W_DEF  = 20;
    localparam int CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // mem_sys bank-select codes
    localparam logic [1:0] BANK_0 = 2'd0;
    localparam logic [1:0] BANK_1 = 2'd1;
    localparam logic [1:0] BANK_2 = 2'd2;
    localparam logic [1:0] BANK_3 = 2'd3;

    // Select value driven while no run is in progress
    localparam logic [1:0] SEL_NONE = BANK_0;

endpackage

// File: rtl/bin_dot_seq_if.sv
// Read/write port bundle towards mem_sys. The sequencer is the master; the
// memory (or a bench model of it) is the slave and returns read data.
interface bin_dot_seq_if #(
    parameter int AW_X = bin_dot_pkg::AW_X_DEF,
    parameter int AW_W = bin_dot_pkg::AW_W_DEF
) ();

    logic            read_rq_x;
    logic            read_rq_w;
    logic            write_rq_x;
    logic            write_rq_w;
    logic [1:0]      sel_x;
    logic [1:0]      sel_w;
    logic [AW_X-1:0] rw_address_x;
    logic [AW_W-1:0] rw_address;
    logic            read_data_x;
    logic            read_data_w;

    modport master (
        output read_rq_x, read_rq_w, write_rq_x, write_rq_w,
        output sel_x, sel_w, rw_address_x, rw_address,
        input  read_data_x, read_data_w
    );

    modport slave (
        input  read_rq_x, read_rq_w, write_rq_x, write_rq_w,
        input  sel_x, sel_w, rw_address_x, rw_address,
        output read_data_x, read_data_w
    );

endinterface

// File: rtl/rd_valid_pipe.sv
// Valid-marker shift register matching mem_sys read latency. A marker enters
// with each sampled read strobe and leaves on the cycle its data is sampled.
// `empty` means no marker will remain in flight after the current edge, so a
// consumer retiring vld_o this cycle knows it is taking the last datum.
module rd_valid_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_i,
    output logic vld_o,
    output logic empty
);

    localparam logic [RD_LAT-1:0] TAIL = RD_LAT'(1) << (RD_LAT - 1);

    logic [RD_LAT-1:0] vld_q;

    generate
        if (RD_LAT == 1) begin : g_single
            // Single-stage marker register
            always_ff @(posedge clk) begin
                if (rst) vld_q[0] <= 1'b0;
                else     vld_q[0] <= vld_i;
            end
        end else begin : g_multi
            // Shift markers towards the tail, one stage per cycle
            always_ff @(posedge clk) begin
                if (rst) vld_q <= '0;
                else     vld_q <= {vld_q[RD_LAT-2:0], vld_i};
            end
        end
    endgenerate

    assign vld_o = vld_q[RD_LAT-1];
    assign empty = !vld_i && ((vld_q & ~TAIL) == '0);

endmodule

// File: rtl/bin_dot_seq.sv
// Binarized-neuron read sequencer: streams len bit pairs out of mem_sys X/W
// memories, counts XNOR matches, and reports the count with a sign bit.
module bin_dot_seq
    import bin_dot_pkg::*;
#(
    parameter int AW_X   = AW_X_DEF,
    parameter int AW_W   = AW_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic [AW_X-1:0]  x_base,
    input  logic [AW_W-1:0]  w_base,
    input  logic [1:0]       sel_x_cfg,
    input  logic [1:0]       sel_w_cfg,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             act,
    bin_dot_seq_if.master    mem
);

    // Activation: at least half of the pairs matched
    function automatic logic act_of(input logic [CNT_W-1:0] cnt,
                                    input logic [CNT_W-1:0] n);
        return {cnt, 1'b0} >= {1'b0, n};
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] i_q;
    logic [CNT_W-1:0] acc_q;
    logic [CNT_W-1:0] acc_d;
    logic [CNT_W-1:0] result_q;
    logic             act_q;
    logic             busy_q;
    logic             done_q;
    logic             rq_q;
    logic [1:0]       sel_x_q;
    logic [1:0]       sel_w_q;
    logic [AW_X-1:0]  addr_x_q;
    logic [AW_W-1:0]  addr_w_q;

    logic             tail_vld;
    logic             pipe_empty;
    logic             match;

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_vld (
        .clk   (clk),
        .rst   (rst),
        .vld_i (rq_q),
        .vld_o (tail_vld),
        .empty (pipe_empty)
    );

    // Count only data that belongs to a request of this run
    assign match = tail_vld & (mem.read_data_x ~^ mem.read_data_w);
    assign acc_d = acc_q + CNT_W'(match);

    // Run control, request generation and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            i_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            act_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rq_q     <= 1'b0;
            sel_x_q  <= SEL_NONE;
            sel_w_q  <= SEL_NONE;
            addr_x_q <= '0;
            addr_w_q <= '0;
        end else begin
            done_q <= 1'b0;
            acc_q  <= acc_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q  <= len;
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        if (len == '0) begin
                            // Empty run: report immediately, touch no memory
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= '0;
                            act_q    <= act_of('0, len);
                        end else begin
                            state_q  <= S_ISSUE;
                            i_q      <= '0;
                            rq_q     <= 1'b1;
                            addr_x_q <= x_base;
                            addr_w_q <= w_base;
                            sel_x_q  <= sel_x_cfg;
                            sel_w_q  <= sel_w_cfg;
                        end
                    end
                end
                S_ISSUE: begin
                    if (i_q == len_q - CNT_W'(1)) begin
                        state_q <= S_DRAIN;
                        rq_q    <= 1'b0;
                    end else begin
                        i_q      <= i_q + CNT_W'(1);
                        addr_x_q <= addr_x_q + AW_X'(1);
                        addr_w_q <= addr_w_q + AW_W'(1);
                    end
                end
                S_DRAIN: begin
                    // The datum retiring now is the last one of the run
                    if (pipe_empty) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                        act_q    <= act_of(acc_d, len_q);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    sel_x_q <= SEL_NONE;
                    sel_w_q <= SEL_NONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign act    = act_q;

    assign mem.read_rq_x    = rq_q;
    assign mem.read_rq_w    = rq_q;
    assign mem.write_rq_x   = 1'b0;
    assign mem.write_rq_w   = 1'b0;
    assign mem.sel_x        = sel_x_q;
    assign mem.sel_w        = sel_w_q;
    assign mem.rw_address_x = addr_x_q;
    assign mem.rw_address   = addr_w_q;

endmodule

// File: tb/tb_bin_dot_seq.sv
// Bench for bin_dot_seq: mem_sys read model with one cycle of latency, a
// run-level reference model checked every cycle, and directed runs with
// hand-computed results.
`timescale 1ns/1ps
module tb_bin_dot_seq;
    import bin_dot_pkg::*;

    localparam int AW_X   = 10;
    localparam int AW_W   = 20;
    localparam int CNT_W  = 11;
    localparam int RD_LAT = 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic [AW_X-1:0]  x_base = '0;
    logic [AW_W-1:0]  w_base = '0;
    logic [1:0]       sel_x_cfg = '0;
    logic [1:0]       sel_w_cfg = '0;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] result;
    logic             act;

    bin_dot_seq_if #(.AW_X(AW_X), .AW_W(AW_W)) mem ();

    bin_dot_seq #(
        .AW_X(AW_X), .AW_W(AW_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .x_base    (x_base),
        .w_base    (w_base),
        .sel_x_cfg (sel_x_cfg),
        .sel_w_cfg (sel_w_cfg),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .act       (act),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    // mem_sys contents and one-cycle read model
    bit xmem [0:1023];
    bit wmem [int];
    logic rdx_q = 1'b0;
    logic rdw_q = 1'b0;

    function automatic bit wrd(input int a);
        return wmem.exists(a) ? wmem[a] : 1'b0;
    endfunction

    always @(posedge clk) begin
        if (mem.read_rq_x) rdx_q <= xmem[mem.rw_address_x];
        if (mem.read_rq_w) rdw_q <= wrd(int'(mem.rw_address));
    end
    assign mem.read_data_x = rdx_q;
    assign mem.read_data_w = rdw_q;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic load_x(input int base, input string bits);
        for (int k = 0; k < bits.len(); k++) xmem[(base + k) % 1024] = (bits[k] == 8'h31);
    endtask

    task automatic load_w(input int base, input string bits);
        for (int k = 0; k < bits.len(); k++) wmem[(base + k) % (1 << AW_W)] = (bits[k] == 8'h31);
    endtask

    // Reference model: one run described by its parameters and cycle index
    bit  m_act = 1'b0;
    int  m_n, m_len, m_xb, m_wb, m_done_n, m_res;
    bit  m_actv;
    int  m_sx, m_sw;
    int  held_res = 0;
    bit  held_act = 1'b0;

    initial begin
        bit rq_exp;
        bit done_exp;
        @(posedge clk);
        forever begin
            @(negedge clk);
            rq_exp   = m_act && (m_n < m_len);
            done_exp = m_act && (m_n == m_done_n);
            chk("write_rq_x", mem.write_rq_x, 0);
            chk("write_rq_w", mem.write_rq_w, 0);
            chk("busy", busy, m_act);
            chk("done", done, done_exp);
            chk("read_rq_x", mem.read_rq_x, rq_exp);
            chk("read_rq_w", mem.read_rq_w, rq_exp);
            if (rq_exp) begin
                chk("addr_x", mem.rw_address_x, (m_xb + m_n) % (1 << AW_X));
                chk("addr_w", mem.rw_address, (m_wb + m_n) % (1 << AW_W));
            end
            chk("sel_x", mem.sel_x, (m_act && m_len > 0) ? m_sx : 0);
            chk("sel_w", mem.sel_w, (m_act && m_len > 0) ? m_sw : 0);
            if (done_exp) begin
                held_res = m_res;
                held_act = m_actv;
            end
            if (!m_act || done_exp) begin
                chk("result", result, held_res);
                chk("act", act, held_act);
            end
            // advance the model to the next cycle
            if (rst) begin
                m_act    = 1'b0;
                held_res = 0;
                held_act = 1'b0;
            end else if (m_act) begin
                if (done_exp) m_act = 1'b0;
                else          m_n++;
            end else if (start) begin
                m_act  = 1'b1;
                m_n    = 0;
                m_len  = int'(len);
                m_xb   = int'(x_base);
                m_wb   = int'(w_base);
                m_sx   = int'(sel_x_cfg);
                m_sw   = int'(sel_w_cfg);
                m_res  = 0;
                for (int k = 0; k < m_len; k++)
                    if (xmem[(m_xb + k) % (1 << AW_X)] == wrd((m_wb + k) % (1 << AW_W))) m_res++;
                m_actv   = (2 * m_res >= m_len);
                m_done_n = (m_len == 0) ? 0 : m_len + RD_LAT;
            end
        end
    end

    // Issue one run; returns edges from the start edge to the edge after which done is seen
    task automatic run(input int l, input int xb, input int wb,
                       input logic [1:0] sx, input logic [1:0] sw,
                       input int poke, output int edges);
        @(posedge clk);
        #1;
        start     = 1'b1;
        len       = CNT_W'(l);
        x_base    = AW_X'(xb);
        w_base    = AW_W'(wb);
        sel_x_cfg = sx;
        sel_w_cfg = sw;
        edges     = 0;
        do begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == poke);
            if (edges == poke) begin
                len    = CNT_W'(4);
                x_base = AW_X'(1022);
                w_base = AW_W'(100);
            end
            @(negedge clk);
        end while (!done && edges < 3000);
        chk("done_seen", done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        load_x(0, "10110010");
        load_w(0, "10110010");
        load_x(16, "11111111");
        load_w(16, "00000000");
        load_x(1022, "10");
        load_w(100, "1110");

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_act", act, 0);
        chk("rst_rq_x", mem.read_rq_x, 0);
        chk("rst_sel_x", mem.sel_x, 0);

        // identical patterns: all 8 positions match
        run(8, 0, 0, BANK_1, BANK_2, 0, e);
        chk("t1_edges", e, 10);
        chk("t1_result", result, 8);
        chk("t1_act", act, 1);

        // complementary patterns: no matches
        run(8, 16, 16, BANK_3, BANK_0, 0, e);
        chk("t2_result", result, 0);
        chk("t2_act", act, 0);

        // empty run
        run(0, 5, 5, BANK_1, BANK_1, 0, e);
        chk("t3_edges", e, 1);
        chk("t3_result", result, 0);
        chk("t3_act", act, 1);

        // X address wrap: X 1,0,1,0 at 1022,1023,0,1 vs W 1,1,1,0
        run(4, 1022, 100, BANK_2, BANK_3, 0, e);
        chk("t4_result", result, 3);
        chk("t4_act", act, 1);

        // reset while request i=3 is presented
        @(posedge clk);
        #1;
        start  = 1'b1;
        len    = CNT_W'(8);
        x_base = '0;
        w_base = '0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("abort_addr_i3", mem.rw_address_x, 3);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rq_x", mem.read_rq_x, 0);
        chk("abort_rq_w", mem.read_rq_w, 0);
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        run(8, 0, 0, BANK_1, BANK_2, 0, e);
        chk("t5_result", result, 8);
        chk("t5_edges", e, 10);

        // start re-asserted mid-run must be ignored
        run(8, 16, 16, BANK_1, BANK_1, 3, e);
        chk("t6_result", result, 0);
        chk("t6_edges", e, 10);

        // full-length all-match run, back to back
        for (int k = 0; k < 1024; k++) wmem[4096 + k] = xmem[k];
        run(1024, 0, 4096, BANK_2, BANK_1, 0, e);
        chk("t7_result", result, 1024);
        chk("t7_act", act, 1);
        chk("t7_edges", e, 1026);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_dot_seq.md
# bin_dot_seq

Read-side sequencer that sits directly downstream of `mem_sys`. On `start`, it walks `len` consecutive 1-bit entries of the X memory and the W memory in lockstep. It counts the positions where the two bits are equal (the XNOR-popcount of a binarized neuron) and reports that count plus a sign/activation bit. It only ever issues read requests. `mem_sys` is loaded beforehand by the existing write path.

## Interface

Parameters:
- `AW_X`, 10: X address width; matches `rw_address_x`.
- `AW_W`, 20: W address width; matches `rw_address`.
- `CNT_W`, 11: width of `len`, counters and result; holds values 0..1024.
- `RD_LAT`, 1: `mem_sys` read latency in cycles, from the edge that samples `read_rq` to the edge where `read_data` is sampled; legal values 1..4.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle command; sampled only in IDLE.
- `len` in CNT_W: number of bit pairs; legal range 0..1024; sampled with `start`.
- `x_base` in AW_X: first X address; sampled with `start`.
- `w_base` in AW_W: first W address; sampled with `start`.
- `sel_x_cfg` in 2: bank select driven onto `sel_x` during a run.
- `sel_w_cfg` in 2: bank select driven onto `sel_w` during a run.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse; `result` and `act` are valid in the same cycle.
- `result` out CNT_W: count of matching bit pairs; held until the next accepted `start` or reset.
- `act` out 1: `2*result >= len`; held with `result`.
- `read_rq_x`, `read_rq_w` out 1: read strobes to `mem_sys`.
- `write_rq_x`, `write_rq_w` out 1: constant 0.
- `sel_x`, `sel_w` out 2: bank selects to `mem_sys`.
- `rw_address_x` out AW_X: X read address.
- `rw_address` out AW_W: W read address.
- `read_data_x`, `read_data_w` in 1: read data from `mem_sys`.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start=1` with `len>0`: latch `len`, both bases and both selects; clear `acc` and the issue counter `i`; go to ISSUE.
  - `start=1` with `len=0`: go to DONE with `acc=0`.
- ISSUE:
  - Every cycle, drive `read_rq_x = read_rq_w = 1`, `rw_address_x = x_base+i` (mod 2^AW_X) and `rw_address = w_base+i` (mod 2^AW_W).
  - Increment `i`.
  - After the request with `i = len-1`, go to DRAIN.
- Valid tracking: a shift register RD_LAT deep marks which cycles carry returning data.
  - When a marked slot arrives: `acc <= acc + (read_data_x ~^ read_data_w)`.
- DRAIN: read strobes are low; when the valid pipe is empty, go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - `done=1`; `result=acc`; `act=(2*acc >= len_latched)`.
  - Next state is IDLE.
- `start` in any state other than IDLE is ignored, with no queuing.
- Address registers wrap silently; no error is raised.
- `sel_x`/`sel_w` hold the latched config throughout a run and hold 0 in IDLE.
- Reset, including mid-run:
  - State returns to IDLE.
  - `busy`, `done`, all `read_rq`/`write_rq`, `sel_*`, addresses, `result`, `act`, `acc` and the valid pipe all go to 0.
  - No `done` is produced for an aborted run.

## Timing

- All memory-side outputs are registered.
- `start` is sampled at edge E0. Requests are presented after edges E0..E(len-1) and sampled by `mem_sys` at E1..E(len).
- The last data is accumulated at edge E(len+RD_LAT). `done` is high in the cycle after that edge.
- Start-to-done latency is `len+RD_LAT+1` edges. For `len=0` it is 1 edge.
- `busy` is high in every cycle from the one after E0 through the `done` cycle, inclusive.
- Back-to-back runs: `start` may be asserted in the cycle immediately after `done`.
- Throughput: one bit pair per cycle; no bubbles within a run.

## Structure

- Shared package `bin_dot_pkg` holds:
  - AW_X, AW_W and CNT_W defaults.
  - The FSM state enum.
  - The 2-bit bank-select code constants.
- Sub-module `rd_valid_pipe`: an RD_LAT-deep valid shift register with an `empty` output, reusable by any other `mem_sys` reader.

## Test plan

- `len=8`, X = W = 10110010 at base 0 → `result=8`, `act=1`, `done` 10 edges after `start` (RD_LAT=1).
- `len=8`, X = 11111111, W = 00000000 → `result=0`, `act=0`.
- `len=0` → `done` in the cycle after `start`, `result=0`, `act=1`, no `read_rq`.
- `x_base=1022`, `len=4` → X addresses 1022, 1023, 0, 1; W addresses `w_base`..`w_base+3`; `result` is correct.
- `rst` pulsed at `i=3` of a `len=8` run → all strobes 0 on the next cycle, `busy=0`, no `done`; a following `start` completes normally.
- `start` re-asserted while `busy`, then a `len=1024` all-match run → the re-assert is ignored, `result=1024` with no overflow, `write_rq_*` stays 0 throughout.
